// File: rtl/l3_gan.sv
// Purpose : fixed 8-layer integer MLP (4-4-2-1-1-1-2-4-4), one layer evaluated per clock.
// Latency : start edge E0 -> out1..out4 valid with done=1 after edge E8 (8 cycles).
// Backpr. : none; start is only honoured in IDLE/DONE, and the weight buses must stay static for a run.
//
// Ports: clk, rst (sync, active-high), start, x1..x4 (signed inputs),
//        L{k}_w / L{k}_b (packed weights/biases, w_ij at slice (j-1)*NIN+(i-1), b_j at slice j-1),
//        out1..out4 (registered layer-8 results), done (level, high only in DONE).
module l3_gan #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_W-1:0]          x1,
  input  logic [DATA_W-1:0]          x2,
  input  logic [DATA_W-1:0]          x3,
  input  logic [DATA_W-1:0]          x4,
  input  logic [16*DATA_W-1:0]       L1_w,
  input  logic [4*DATA_W-1:0]        L1_b,
  input  logic [8*DATA_W-1:0]        L2_w,
  input  logic [2*DATA_W-1:0]        L2_b,
  input  logic [2*DATA_W-1:0]        L3_w,
  input  logic [DATA_W-1:0]          L3_b,
  input  logic [DATA_W-1:0]          L4_w,
  input  logic [DATA_W-1:0]          L4_b,
  input  logic [DATA_W-1:0]          L5_w,
  input  logic [DATA_W-1:0]          L5_b,
  input  logic [2*DATA_W-1:0]        L6_w,
  input  logic [2*DATA_W-1:0]        L6_b,
  input  logic [8*DATA_W-1:0]        L7_w,
  input  logic [4*DATA_W-1:0]        L7_b,
  input  logic [16*DATA_W-1:0]       L8_w,
  input  logic [4*DATA_W-1:0]        L8_b,
  output logic signed [DATA_W-1:0]   out1,
  output logic signed [DATA_W-1:0]   out2,
  output logic signed [DATA_W-1:0]   out3,
  output logic signed [DATA_W-1:0]   out4,
  output logic                       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_L4, S_L5, S_L6, S_L7, S_L8, S_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

  state_t state, state_nxt;
  logic   load_x;

  // Shared activation file: holds latched x, then each layer's result in turn.
  logic signed [DATA_W-1:0] act [4];
  logic signed [DATA_W-1:0] res [4];

  // Current layer's weights/bias mapped onto a uniform 4x4 array; unused
  // entries stay zero, so unused neurons evaluate to 0 and stale act
  // entries beyond the layer's fan-in contribute nothing.
  logic signed [DATA_W-1:0] wm [4][4];
  logic signed [DATA_W-1:0] bv [4];
  logic                     relu;
  logic signed [ACC_W-1:0]  acc [4];

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      bv[j] = '0;
      for (int i = 0; i < 4; i++) wm[j][i] = '0;
    end
    relu = 1'b1;
    case (state)
      S_L1: for (int j = 0; j < 4; j++) begin
        bv[j] = L1_b[j*DATA_W +: DATA_W];
        for (int i = 0; i < 4; i++) wm[j][i] = L1_w[(j*4+i)*DATA_W +: DATA_W];
      end
      S_L2: for (int j = 0; j < 2; j++) begin
        bv[j] = L2_b[j*DATA_W +: DATA_W];
        for (int i = 0; i < 4; i++) wm[j][i] = L2_w[(j*4+i)*DATA_W +: DATA_W];
      end
      S_L3: begin
        bv[0]    = L3_b;
        wm[0][0] = L3_w[0 +: DATA_W];
        wm[0][1] = L3_w[DATA_W +: DATA_W];
      end
      S_L4: begin
        bv[0]    = L4_b;
        wm[0][0] = L4_w;
      end
      S_L5: begin
        bv[0]    = L5_b;
        wm[0][0] = L5_w;
      end
      S_L6: for (int j = 0; j < 2; j++) begin
        bv[j]    = L6_b[j*DATA_W +: DATA_W];
        wm[j][0] = L6_w[j*DATA_W +: DATA_W];
      end
      S_L7: for (int j = 0; j < 4; j++) begin
        bv[j] = L7_b[j*DATA_W +: DATA_W];
        for (int i = 0; i < 2; i++) wm[j][i] = L7_w[(j*2+i)*DATA_W +: DATA_W];
      end
      S_L8: begin
        relu = 1'b0;
        for (int j = 0; j < 4; j++) begin
          bv[j] = L8_b[j*DATA_W +: DATA_W];
          for (int i = 0; i < 4; i++) wm[j][i] = L8_w[(j*4+i)*DATA_W +: DATA_W];
        end
      end
      default: ;
    endcase
  end

  // Neuron datapath: full-precision signed MAC, then ReLU and 16-bit clamp.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      acc[j] = ACC_W'(bv[j]);
      for (int i = 0; i < 4; i++)
        acc[j] = acc[j] + ACC_W'(act[i]) * ACC_W'(wm[j][i]);
      if (relu && acc[j] < 0)     res[j] = '0;
      else if (acc[j] > SAT_MAX)  res[j] = 16'sh7fff;
      else if (acc[j] < SAT_MIN)  res[j] = 16'sh8000;
      else                        res[j] = acc[j][DATA_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    load_x    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) begin
        state_nxt = S_L1;
        load_x    = 1'b1;
      end
      S_L1: state_nxt = S_L2;
      S_L2: state_nxt = S_L3;
      S_L3: state_nxt = S_L4;
      S_L4: state_nxt = S_L5;
      S_L5: state_nxt = S_L6;
      S_L6: state_nxt = S_L7;
      S_L7: state_nxt = S_L8;
      S_L8: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
      out1  <= '0;
      out2  <= '0;
      out3  <= '0;
      out4  <= '0;
      for (int i = 0; i < 4; i++) act[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == S_DONE);
      if (load_x) begin
        act[0] <= x1;
        act[1] <= x2;
        act[2] <= x3;
        act[3] <= x4;
      end else if (state != S_IDLE && state != S_DONE) begin
        for (int i = 0; i < 4; i++) act[i] <= res[i];
      end
      if (state == S_L8) begin
        out1 <= res[0];
        out2 <= res[1];
        out3 <= res[2];
        out4 <= res[3];
      end
    end
  end

endmodule

// File: tb/tb_l3_gan.sv
// Purpose : scoreboard bench for l3_gan: directed vectors plus random runs against a layer-level model.
// Latency : expects done exactly 8 cycles after the start edge.
// Backpr. : none; stimulus waits for done (bounded) before issuing the next run.
module tb_l3_gan;

  typedef int vec4_t [4];
  typedef int arr16_t [16];
  typedef struct {
    vec4_t o;
    int    cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  x1, x2, x3, x4;
  logic [255:0] L1_w; logic [63:0] L1_b;
  logic [127:0] L2_w; logic [31:0] L2_b;
  logic [31:0]  L3_w; logic [15:0] L3_b;
  logic [15:0]  L4_w; logic [15:0] L4_b;
  logic [15:0]  L5_w; logic [15:0] L5_b;
  logic [31:0]  L6_w; logic [31:0] L6_b;
  logic [127:0] L7_w; logic [63:0] L7_b;
  logic [255:0] L8_w; logic [63:0] L8_b;
  logic signed [15:0] out1, out2, out3, out4;
  logic         done;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb [$];

  l3_gan dut (
    .clk(clk), .rst(rst), .start(start),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .L1_w(L1_w), .L1_b(L1_b), .L2_w(L2_w), .L2_b(L2_b),
    .L3_w(L3_w), .L3_b(L3_b), .L4_w(L4_w), .L4_b(L4_b),
    .L5_w(L5_w), .L5_b(L5_b), .L6_w(L6_w), .L6_b(L6_b),
    .L7_w(L7_w), .L7_b(L7_b), .L8_w(L8_w), .L8_b(L8_b),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint wsel(input int l, input int idx);
    logic [15:0] s;
    case (l)
      1: s = L1_w[16*idx +: 16];
      2: s = L2_w[16*idx +: 16];
      3: s = L3_w[16*idx +: 16];
      4: s = L4_w;
      5: s = L5_w;
      6: s = L6_w[16*idx +: 16];
      7: s = L7_w[16*idx +: 16];
      default: s = L8_w[16*idx +: 16];
    endcase
    return longint'($signed(s));
  endfunction

  function automatic longint bsel(input int l, input int j);
    logic [15:0] s;
    case (l)
      1: s = L1_b[16*j +: 16];
      2: s = L2_b[16*j +: 16];
      3: s = L3_b;
      4: s = L4_b;
      5: s = L5_b;
      6: s = L6_b[16*j +: 16];
      7: s = L7_b[16*j +: 16];
      default: s = L8_b[16*j +: 16];
    endcase
    return longint'($signed(s));
  endfunction

  function automatic vec4_t model(input int a0, input int a1, input int a2, input int a3);
    int     nin  [8] = '{4, 4, 2, 1, 1, 1, 2, 4};
    int     nout [8] = '{4, 2, 1, 1, 1, 2, 4, 4};
    longint a [4];
    longint n [4];
    longint s;
    vec4_t  r;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int l = 1; l <= 8; l++) begin
      for (int j = 0; j < 4; j++) begin
        n[j] = 0;
        if (j < nout[l-1]) begin
          s = bsel(l, j);
          for (int i = 0; i < nin[l-1]; i++) s += a[i] * wsel(l, j*nin[l-1] + i);
          if (l < 8 && s < 0) s = 0;
          if (s > 32767)  s = 32767;
          if (s < -32768) s = -32768;
          n[j] = s;
        end
      end
      a = n;
    end
    for (int j = 0; j < 4; j++) r[j] = int'(a[j]);
    return r;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [255:0] pack(input arr16_t v);
    logic [255:0] p;
    p = '0;
    for (int k = 0; k < 16; k++) p[16*k +: 16] = 16'(v[k]);
    return p;
  endfunction

  function automatic logic [255:0] rbus(input int n, input int span);
    logic [255:0] p;
    p = '0;
    for (int k = 0; k < n; k++)
      p[16*k +: 16] = 16'(int'($urandom_range(0, 2*span)) - span);
    return p;
  endfunction

  task automatic clear_all();
    L1_w = '0; L1_b = '0; L2_w = '0; L2_b = '0; L3_w = '0; L3_b = '0;
    L4_w = '0; L4_b = '0; L5_w = '0; L5_b = '0; L6_w = '0; L6_b = '0;
    L7_w = '0; L7_b = '0; L8_w = '0; L8_b = '0;
  endtask

  task automatic load_full_vector();
    logic [255:0] t;
    L1_w = pack('{6,-3,5,-16, 21,16,-6,-9, 3,-3,-15,-17, 18,12,-4,-8});
    t = pack('{1,0,2,-1, 0,0,0,0, 0,0,0,0, 0,0,0,0});          L1_b = t[63:0];
    t = pack('{4,14,8,15, -14,14,9,15, 0,0,0,0, 0,0,0,0});     L2_w = t[127:0];
    t = pack('{1,4, 0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});          L2_b = t[31:0];
    t = pack('{14,6, 0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});         L3_w = t[31:0];
    L3_b = 16'd5;
    L4_w = 16'd7;  L4_b = 16'd10;
    L5_w = 16'd1;  L5_b = -16'sd4;
    t = pack('{-8,14, 0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});        L6_w = t[31:0];
    t = pack('{20,0, 0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});         L6_b = t[31:0];
    t = pack('{4,-14, 14,14, 8,9, 15,15, 0,0,0,0, 0,0,0,0});   L7_w = t[127:0];
    t = pack('{5,3,1,2, 0,0,0,0, 0,0,0,0, 0,0,0,0});           L7_b = t[63:0];
    L8_w = pack('{11,9,10,1, -7,-6,-15,17, 10,11,-5,4, -7,-7,7,12});
    t = pack('{-10,10,10,-10, 0,0,0,0, 0,0,0,0, 0,0,0,0});     L8_b = t[63:0];
  endtask

  task automatic load_random(input int span);
    logic [255:0] t;
    L1_w = rbus(16, span);  t = rbus(4, 100); L1_b = t[63:0];
    t = rbus(8, span);  L2_w = t[127:0]; t = rbus(2, 100); L2_b = t[31:0];
    t = rbus(2, span);  L3_w = t[31:0];  t = rbus(1, 100); L3_b = t[15:0];
    t = rbus(1, span);  L4_w = t[15:0];  t = rbus(1, 100); L4_b = t[15:0];
    t = rbus(1, span);  L5_w = t[15:0];  t = rbus(1, 100); L5_b = t[15:0];
    t = rbus(2, span);  L6_w = t[31:0];  t = rbus(2, 100); L6_b = t[31:0];
    t = rbus(8, span);  L7_w = t[127:0]; t = rbus(4, 100); L7_b = t[63:0];
    L8_w = rbus(16, span); t = rbus(4, 100); L8_b = t[63:0];
  endtask

  // Drive start for one cycle; returns the cycle count at which done must first be seen.
  task automatic kick(input int a0, input int a1, input int a2, input int a3, output int ecyc);
    @(negedge clk);
    x1 = 16'(a0); x2 = 16'(a1); x3 = 16'(a2); x4 = 16'(a3);
    start = 1'b1;
    ecyc = cyc + 9;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input vec4_t o, input int ecyc);
    exp_t e;
    e.o = o;
    e.cyc = ecyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done, 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("out1", out1, e.o[0]);
          chk("out2", out2, e.o[1]);
          chk("out3", out3, e.o[2]);
          chk("out4", out4, e.o[3]);
        end
      end
      prev = done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int    ec;
    int    ra [4];
    vec4_t full_exp;
    full_exp = '{32767, -32768, 32767, 32767};
    rst = 1'b1; start = 1'b0;
    x1 = '0; x2 = '0; x3 = '0; x4 = '0;
    clear_all();

    // Reset state and idle hold
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_out1", out1, 0); chk("rst_out2", out2, 0);
    chk("rst_out3", out3, 0); chk("rst_out4", out4, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_done", done, 0);

    // Bias-only: layer 8 bias reaches the outputs, negatives pass the linear layer
    L8_b = {16'sd4, -16'sd3, 16'sd2, 16'sd1};
    kick(0, 0, 0, 0, ec);
    push('{1, 2, -3, 4}, ec);
    wait_done("bias_done");

    // Pass-through chain
    clear_all();
    L1_w[15:0] = 16'd1; L2_w[15:0] = 16'd1; L3_w[15:0] = 16'd1;
    L4_w = 16'd1; L5_w = 16'd1;
    L6_w[15:0] = 16'd1; L7_w[15:0] = 16'd1; L8_w[15:0] = 16'd1;
    kick(7, 0, 0, 0, ec);
    push('{7, 0, 0, 0}, ec);
    wait_done("pass_pos_done");
    kick(-7, 0, 0, 0, ec);
    push('{0, 0, 0, 0}, ec);
    wait_done("pass_neg_done");

    // Full vector with saturation
    load_full_vector();
    kick(0, 1, 1, 0, ec);
    push(full_exp, ec);
    wait_done("full_done");

    // start during L4 ignored, and mid-run x changes have no effect
    kick(0, 1, 1, 0, ec);
    push(full_exp, ec);
    repeat (3) @(negedge clk);
    x1 = 16'd5; x2 = 16'd5; x3 = 16'd5; x4 = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_done");

    // restart from DONE: done drops right after the start edge
    for (int i = 0; i < 4; i++) ra[i] = int'($urandom_range(0, 40)) - 20;
    kick(ra[0], ra[1], ra[2], ra[3], ec);
    push(model(ra[0], ra[1], ra[2], ra[3]), ec);
    chk("restart_done_low", done, 0);
    wait_done("restart_done");

    // reset during L5 aborts the run
    kick(0, 1, 1, 0, ec);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_done", done, 0);
    chk("midrst_out1", out1, 0); chk("midrst_out2", out2, 0);
    chk("midrst_out3", out3, 0); chk("midrst_out4", out4, 0);
    repeat (12) @(negedge clk);
    chk("midrst_idle", done, 0);
    kick(0, 1, 1, 0, ec);
    push(full_exp, ec);
    wait_done("after_rst_done");

    // Random runs against the model; later ones use wide weights to saturate
    for (int r = 0; r < 24; r++) begin
      load_random(r < 16 ? 30 : 3000);
      for (int i = 0; i < 4; i++) ra[i] = int'($urandom_range(0, 400)) - 200;
      kick(ra[0], ra[1], ra[2], ra[3], ec);
      push(model(ra[0], ra[1], ra[2], ra[3]), ec);
      wait_done("rand_done");
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
